instr_fetch_unit: RTL

Multi-cycle instruction fetch stage for the 32-bit non-pipelined processor. It holds the PC and issues a request/ready read to instruction memory. It latches the returned word into the instruction register and presents the decoded fields (opcode, rs, rt, rd, imm16) to the decode and execute logic. imm16 drives the 16-to-32 sign extender directly downstream; pc_plus4 feeds branch-target arithmetic.

---
 rtl/instr_fetch_unit.sv | 91 +++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: multi-cycle fetch stage holding the PC, requesting instruction memory and presenting the
// instruction register with decoded fields. Optional macro FETCH_TIMEOUT_EN bounds the REQ wait and errors out.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [15:0] imm16,
    output logic        fetch_err
);
    typedef enum logic [1:0] {REQ, HOLD, ERR} state_t;
    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, instr_q, instr_d;
`ifdef FETCH_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CW-1:0] cnt_q, cnt_d;
`endif
    // next state: capture on ready, advance or redirect out of HOLD, misaligned redirect traps in ERR
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
`ifdef FETCH_TIMEOUT_EN
        cnt_d   = (state_q == REQ && !imem_ready) ? cnt_q + 1'b1 : '0;
`endif
        case (state_q)
            REQ: begin
                if (imem_ready) begin
                    instr_d = imem_rdata;
                    state_d = HOLD;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (32'(cnt_q) + 32'd1 >= TIMEOUT_CYCLES) state_d = ERR;
`endif
            end
            HOLD: begin
                if (!stall) begin
                    pc_d    = branch_taken ? branch_target : pc_q + 32'd4;
                    state_d = (branch_taken && branch_target[1:0] != 2'b00) ? ERR : REQ;
                end
            end
            default: state_d = ERR;
        endcase
    end
    // state registers with synchronous reset; reset wins over a same-cycle ready
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= REQ;
            pc_q    <= RESET_PC;
            instr_q <= '0;
`ifdef FETCH_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
`ifdef FETCH_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end
    assign imem_req    = (state_q == REQ) && !reset;
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign pc_plus4    = pc_q + 32'd4;
    assign instr       = instr_q;
    assign instr_valid = (state_q == HOLD);
    assign fetch_err   = (state_q == ERR);
    assign opcode      = instr_q[31:26];
    assign rs          = instr_q[25:21];
    assign rt          = instr_q[20:16];
    assign rd          = instr_q[15:11];
    assign imm16       = instr_q[15:0];
endmodule
